// File: rtl/matrix_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mac_engine
// Description : Sequential signed matrix multiply-accumulate, C (+)= A x B,
//               one MAC per cycle, k innermost, then column, then row.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mac_engine #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 2,
    parameter int INNER  = 2,
    parameter int COLS   = 2,
    parameter int ACC_W  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*INNER*DATA_W-1:0]   mat_a,
    input  logic [INNER*COLS*DATA_W-1:0]   mat_b,
    input  logic                           start,
    input  logic                           accum,
    output logic                           busy,
    output logic                           done,
    output logic [ROWS*COLS*ACC_W-1:0]     result
);

    localparam int AN  = ROWS * INNER;
    localparam int BN  = INNER * COLS;
    localparam int CN  = ROWS * COLS;
    localparam int RW  = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int CW  = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int KW  = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int AIW = (AN > 1) ? $clog2(AN) : 1;
    localparam int BIW = (BN > 1) ? $clog2(BN) : 1;
    localparam int CIW = (CN > 1) ? $clog2(CN) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [RW-1:0]            r_q, r_d;
    logic [CW-1:0]            c_q, c_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     accum_q, accum_d;
    logic signed [DATA_W-1:0] a_q [AN];
    logic signed [DATA_W-1:0] a_d [AN];
    logic signed [DATA_W-1:0] b_q [BN];
    logic signed [DATA_W-1:0] b_d [BN];
    logic signed [ACC_W-1:0]  res_q [CN];
    logic signed [ACC_W-1:0]  res_d [CN];

    logic                     r_last, c_last, k_last;
    logic [AIW-1:0]           a_idx;
    logic [BIW-1:0]           b_idx;
    logic [CIW-1:0]           c_idx;
    logic signed [ACC_W-1:0]  a_ext, b_ext, prod, seed, sum;

    assign r_last = (r_q == RW'(ROWS - 1));
    assign c_last = (c_q == CW'(COLS - 1));
    assign k_last = (k_q == KW'(INNER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            accum_q <= 1'b0;
            for (int i = 0; i < AN; i++) a_q[i]   <= '0;
            for (int i = 0; i < BN; i++) b_q[i]   <= '0;
            for (int i = 0; i < CN; i++) res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            accum_q <= accum_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (r_last && c_last && k_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Operands are widened to ACC_W before multiplying: the low ACC_W bits of
    // the product are exact, which gives the required wrap-around truncation.
    always_comb begin
        a_idx = AIW'(int'(r_q) * INNER + int'(k_q));
        b_idx = BIW'(int'(k_q) * COLS + int'(c_q));
        c_idx = CIW'(int'(r_q) * COLS + int'(c_q));
        a_ext = ACC_W'(a_q[a_idx]);
        b_ext = ACC_W'(b_q[b_idx]);
        prod  = a_ext * b_ext;
        seed  = (k_q == '0) ? (accum_q ? res_q[c_idx] : '0) : acc_q;
        sum   = seed + prod;
    end

    always_comb begin
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        accum_d = accum_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        if (state_q == ST_IDLE && start) begin
            for (int i = 0; i < AN; i++) a_d[i] = mat_a[i*DATA_W +: DATA_W];
            for (int i = 0; i < BN; i++) b_d[i] = mat_b[i*DATA_W +: DATA_W];
            accum_d = accum;
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
            acc_d   = '0;
        end else if (state_q == ST_RUN) begin
            acc_d = sum;
            if (k_last) begin
                res_d[c_idx] = sum;
                k_d          = '0;
                if (c_last) begin
                    c_d = '0;
                    r_d = r_last ? '0 : r_q + RW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < CN; i++) begin : g_result
            assign result[i*ACC_W +: ACC_W] = res_q[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_mac_engine
// Description : Directed self-checking bench for matrix_mac_engine, default
//               2x2x2 instance plus 3x1x4 and 1x4x1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mac_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] mat_a = '0, mat_b = '0;
    logic         start = 1'b0, accum = 1'b0;
    logic         busy, done;
    logic [127:0] result;

    logic [95:0]  s1_a = '0;
    logic [127:0] s1_b = '0;
    logic         s1_start = 1'b0, s1_accum = 1'b0, s1_busy, s1_done;
    logic [383:0] s1_res, s1_exp;

    logic [127:0] s2_a = '0, s2_b = '0;
    logic         s2_start = 1'b0, s2_accum = 1'b0, s2_busy, s2_done;
    logic [31:0]  s2_res, s2_exp;

    int n_checks = 0;
    int n_err    = 0;
    int lat, busy_n, done_n, n, acc_i;
    int rises, dones, consec, last_rise, bad_gap;
    logic prev_busy, prev_done;
    logic [127:0] mid;

    always #5 clk = ~clk;

    matrix_mac_engine u_dut (
        .clk(clk), .rst(rst), .mat_a(mat_a), .mat_b(mat_b), .start(start),
        .accum(accum), .busy(busy), .done(done), .result(result)
    );

    matrix_mac_engine #(.DATA_W(32), .ROWS(3), .INNER(1), .COLS(4), .ACC_W(32)) u_dut_s1 (
        .clk(clk), .rst(rst), .mat_a(s1_a), .mat_b(s1_b), .start(s1_start),
        .accum(s1_accum), .busy(s1_busy), .done(s1_done), .result(s1_res)
    );

    matrix_mac_engine #(.DATA_W(32), .ROWS(1), .INNER(4), .COLS(1), .ACC_W(32)) u_dut_s2 (
        .clk(clk), .rst(rst), .mat_a(s2_a), .mat_b(s2_b), .start(s2_start),
        .accum(s2_accum), .busy(s2_busy), .done(s2_done), .result(s2_res)
    );

    function automatic logic [127:0] p4(input int e0, input int e1, input int e2, input int e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; start is accepted on the next edge.
    // Inputs are scrambled right after acceptance to prove they were captured.
    task automatic job(input logic [127:0] a, input logic [127:0] b, input logic acc,
                       output int l, output int bn, output int dn, output logic [127:0] m);
        int k;
        mat_a = a; mat_b = b; accum = acc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mat_a = {$urandom, $urandom, $urandom, $urandom};
        mat_b = {$urandom, $urandom, $urandom, $urandom};
        accum = ~acc;
        k = 0; bn = 0; dn = 0; l = -1; m = '0;
        while (l < 0 && k < 64) begin
            if (busy) bn++;
            if (k == 2) m = result;
            if (done) begin
                dn++;
                l = k + 1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        @(negedge clk);
        if (busy) bn++;
        if (done) dn++;
    endtask

    initial begin
        // Reset held with start high: nothing may begin.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);

        // First edge with rst low accepts the pending start.
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("first_edge_accept", busy, 1'b1);
        n = 0;
        while (!done && n < 64) begin @(negedge clk); n++; end
        check("first_job_done_seen", done, 1'b1);
        @(negedge clk);

        job(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 1'b0, lat, busy_n, done_n, mid);
        check("basic_result", result, p4(19, 22, 43, 50));
        check("basic_latency", lat, 9);
        check("basic_busy_cycles", busy_n, 9);
        check("basic_done_pulses", done_n, 1);

        job(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 1'b1, lat, busy_n, done_n, mid);
        check("accum_result", result, p4(38, 44, 86, 100));
        check("accum_latency", lat, 9);

        job(p4(0, 0, 0, 0), p4(5, 6, 7, 8), 1'b0, lat, busy_n, done_n, mid);
        check("zero_midrun_hold", mid, p4(0, 44, 86, 100));
        check("zero_result", result, '0);

        job(p4(-1, 0, 0, -1), p4(3, -4, 5, 6), 1'b0, lat, busy_n, done_n, mid);
        check("signed_result", result, p4(-3, 4, -5, -6));

        job(p4(32'h10000, 0, 0, 0), p4(32'h10000, 0, 0, 0), 1'b0, lat, busy_n, done_n, mid);
        check("wrap_result", result, '0);

        job(p4(32'h7fff_ffff, 0, 0, 0), p4(2, 0, 0, 0), 1'b1, lat, busy_n, done_n, mid);
        check("wrap_accum_result", result, p4(-2, 0, 0, 0));

        // start held high: one job per 10 cycles, start during RUN ignored.
        mat_a = p4(1, 2, 3, 4); mat_b = p4(5, 6, 7, 8); accum = 1'b0; start = 1'b1;
        prev_busy = 1'b0; prev_done = 1'b0;
        rises = 0; dones = 0; consec = 0; last_rise = -1; bad_gap = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                rises++;
                if (last_rise >= 0 && i - last_rise != 10) bad_gap++;
                last_rise = i;
            end
            if (done && prev_done) consec++;
            if (done) dones++;
            prev_busy = busy;
            prev_done = done;
        end
        start = 1'b0;
        check("held_jobs_accepted", rises, 3);
        check("held_accept_spacing", bad_gap, 0);
        check("held_done_count", dones, 3);
        check("held_done_consecutive", consec, 0);
        check("held_result", result, p4(19, 22, 43, 50));

        // Reset in the fourth RUN cycle.
        @(negedge clk);
        mat_a = p4(1, 1, 1, 1); mat_b = p4(1, 1, 1, 1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, '0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        job(p4(2, 0, 0, 2), p4(5, 6, 7, 8), 1'b0, lat, busy_n, done_n, mid);
        check("after_rst_result", result, p4(10, 12, 14, 16));
        check("after_rst_latency", lat, 9);

        // Sweep ROWS=3 INNER=1 COLS=4.
        for (int i = 0; i < 3; i++) s1_a[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) s1_b[i*32 +: 32] = $urandom;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                acc_i = int'(s1_a[r*32 +: 32]) * int'(s1_b[c*32 +: 32]);
                s1_exp[(r*4 + c)*32 +: 32] = acc_i;
            end
        s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        n = 0; lat = -1;
        while (lat < 0 && n < 64) begin
            if (s1_done) lat = n + 1;
            else begin @(negedge clk); n++; end
        end
        check("s1_latency", lat, 13);
        check("s1_result", s1_res, s1_exp);
        @(negedge clk);

        // Sweep ROWS=1 INNER=4 COLS=1.
        for (int i = 0; i < 4; i++) s2_a[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) s2_b[i*32 +: 32] = $urandom;
        acc_i = 0;
        for (int k = 0; k < 4; k++) acc_i += int'(s2_a[k*32 +: 32]) * int'(s2_b[k*32 +: 32]);
        s2_exp = acc_i;
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        n = 0; lat = -1;
        while (lat < 0 && n < 64) begin
            if (s2_done) lat = n + 1;
            else begin @(negedge clk); n++; end
        end
        check("s2_latency", lat, 5);
        check("s2_result", s2_res, s2_exp);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
